fetch_stage: RTL and testbench

Instruction-fetch stage that sits between the program counter register and decode. It consumes the current PC (address) and drives next_address back into the PC register. It also runs the instruction-memory request/ready handshake and owns the IF/ID pipeline register. Stall, flush/redirect and a one-entry skid buffer keep the PC, the memory and the IF/ID register consistent.

---
 rtl/fetch_stage_pkg.sv | 16 +
 rtl/fetch_stage_if_id_reg.sv | 48 ++++
 rtl/fetch_stage.sv | 148 ++++++++++++++
 tb/tb_fetch_stage.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared widths, the NOP word and the fetch FSM encoding for the fetch stage and its IF/ID register.
package fetch_stage_pkg;
    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic {
        FS_REQ  = 1'b0,
        FS_HOLD = 1'b1
    } fetch_state_e;

    // Instructions are halfword aligned, so redirect targets drop bit 0.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:1], 1'b0};
    endfunction
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: priority reset > clear > hold > load.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               hold_i,
    input  logic               clear_i,
    input  logic               clear_instr_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic [ADDR_W-1:0]  pc_plus2_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [ADDR_W-1:0]  pc_plus2_o
);
    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_plus2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus2_q <= '0;
        end else if (clear_i) begin
            // A bubble only drops valid; a flush also scrubs the instruction word.
            valid_q <= 1'b0;
            if (clear_instr_i) begin
                instr_q <= NOP_INSTR;
            end
        end else if (!hold_i && load_i) begin
            valid_q    <= 1'b1;
            instr_q    <= instr_i;
            pc_q       <= pc_i;
            pc_plus2_q <= pc_plus2_i;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus2_o = pc_plus2_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: next-PC mux, imem handshake FSM with a one-entry skid buffer, IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_ADDR = 16'h0000,
    parameter logic [ADDR_W-1:0] PC_STEP    = 16'd2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  address,
    output logic [ADDR_W-1:0]  next_address,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [ADDR_W-1:0]  if_id_pc_plus2
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_bubbles
`endif
);
    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

    logic               ld_load, ld_hold, ld_clear, ld_clear_instr;
    logic [ADDR_W-1:0]  ld_pc;
    logic [INSTR_W-1:0] ld_instr;

    assign imem_addr = address;

    always_comb begin
        state_d        = state_q;
        skid_pc_d      = skid_pc_q;
        skid_instr_d   = skid_instr_q;
        next_address   = address;
        imem_req       = 1'b0;
        ld_load        = 1'b0;
        ld_hold        = 1'b0;
        ld_clear       = 1'b0;
        ld_clear_instr = 1'b0;
        ld_pc          = address;
        ld_instr       = imem_rdata;

        if (rst) begin
            next_address = RESET_ADDR;
            state_d      = FS_REQ;
        end else begin
            case (state_q)
                FS_REQ: begin
                    imem_req = 1'b1;
                    if (flush) begin
                        next_address   = align_pc(redirect_target);
                        ld_clear       = 1'b1;
                        ld_clear_instr = 1'b1;
                    end else if (stall) begin
                        ld_hold = 1'b1;
                        if (imem_ready) begin
                            // Park the returned word; the PC moves on so the access is not repeated.
                            skid_pc_d    = address;
                            skid_instr_d = imem_rdata;
                            next_address = address + PC_STEP;
                            state_d      = FS_HOLD;
                        end
                    end else if (imem_ready) begin
                        ld_load      = 1'b1;
                        next_address = address + PC_STEP;
                    end else begin
                        ld_clear = 1'b1;
                    end
                end
                FS_HOLD: begin
                    if (flush) begin
                        next_address = align_pc(redirect_target);
                        ld_clear     = 1'b1;
                        state_d      = FS_REQ;
                    end else if (stall) begin
                        ld_hold = 1'b1;
                    end else begin
                        ld_load  = 1'b1;
                        ld_pc    = skid_pc_q;
                        ld_instr = skid_instr_q;
                        state_d  = FS_REQ;
                    end
                end
                default: state_d = FS_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FS_REQ;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk           (clk),
        .rst           (rst),
        .load_i        (ld_load),
        .hold_i        (ld_hold),
        .clear_i       (ld_clear),
        .clear_instr_i (ld_clear_instr),
        .instr_i       (ld_instr),
        .pc_i          (ld_pc),
        .pc_plus2_i    (ld_pc + PC_STEP),
        .valid_o       (if_id_valid),
        .instr_o       (if_id_instr),
        .pc_o          (if_id_pc),
        .pc_plus2_o    (if_id_pc_plus2)
    );

`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched_q, perf_bubbles_q;

    // Every clear of the IF/ID register is either a wait-state bubble or a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
        end else begin
            if (ld_load && !ld_hold && !ld_clear && perf_fetched_q != 16'hFFFF) begin
                perf_fetched_q <= perf_fetched_q + 16'd1;
            end
            if (ld_clear && perf_bubbles_q != 16'hFFFF) begin
                perf_bubbles_q <= perf_bubbles_q + 16'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; the bench itself plays the PC register and an instruction memory.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_ready = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] redirect_target = 16'h0000;
    logic [15:0] address = 16'h1234;
    logic [15:0] next_address, imem_addr, imem_rdata;
    logic [15:0] if_id_instr, if_id_pc, if_id_pc_plus2;
    logic        imem_req, if_id_valid;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched, perf_bubbles;
    logic [15:0] snap_fetched, snap_bubbles;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Program counter register and an instruction memory returning address ^ A5A5.
    always @(posedge clk) address <= next_address;
    assign imem_rdata = imem_addr ^ 16'hA5A5;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .address         (address),
        .next_address    (next_address),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .flush           (flush),
        .redirect_target (redirect_target),
        .if_id_valid     (if_id_valid),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus2  (if_id_pc_plus2)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_bubbles    (perf_bubbles)
`endif
    );

    task automatic drive(input logic r, input logic rdy, input logic st, input logic fl,
                         input logic [15:0] tgt);
        @(negedge clk);
        rst = r; imem_ready = rdy; stall = st; flush = fl; redirect_target = tgt;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        total++; if (next_address !== 16'h0000) begin bad++; $display("FAIL reset_next: got %h want 0000", next_address); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
        total++; if (if_id_pc !== 16'h0000) begin bad++; $display("FAIL reset_pc: got %h want 0000", if_id_pc); end
        $display("reset: next=%h req=%b valid=%b", next_address, imem_req, if_id_valid);
    endtask

    task automatic test_streaming();
        logic [15:0] exp_instr [4] = '{16'hA5A5, 16'hA5A7, 16'hA5A1, 16'hA5A3};
        for (int n = 0; n < 4; n++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
            total++; if (imem_addr !== 16'(2 * n)) begin bad++; $display("FAIL stream_addr%0d: got %h want %h", n, imem_addr, 16'(2 * n)); end
            total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL stream_req%0d: got %b want 1", n, imem_req); end
            total++; if (next_address !== 16'(2 * n + 2)) begin bad++; $display("FAIL stream_next%0d: got %h want %h", n, next_address, 16'(2 * n + 2)); end
            if (n > 0) begin
                total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL stream_valid%0d: got %b want 1", n, if_id_valid); end
                total++; if (if_id_pc !== 16'(2 * n - 2)) begin bad++; $display("FAIL stream_pc%0d: got %h want %h", n, if_id_pc, 16'(2 * n - 2)); end
                total++; if (if_id_instr !== exp_instr[n-1]) begin bad++; $display("FAIL stream_instr%0d: got %h want %h", n, if_id_instr, exp_instr[n-1]); end
                total++; if (if_id_pc_plus2 !== 16'(2 * n)) begin bad++; $display("FAIL stream_pc2_%0d: got %h want %h", n, if_id_pc_plus2, 16'(2 * n)); end
            end
            $display("stream %0d: addr=%h valid=%b pc=%h instr=%h", n, imem_addr, if_id_valid, if_id_pc, if_id_instr);
        end
    endtask

    task automatic test_wait_states();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
            total++; if (imem_addr !== 16'h0008) begin bad++; $display("FAIL wait_addr%0d: got %h want 0008", k, imem_addr); end
            total++; if (next_address !== 16'h0008) begin bad++; $display("FAIL wait_next%0d: got %h want 0008", k, next_address); end
            total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL wait_req%0d: got %b want 1", k, imem_req); end
            if (k == 0) begin
                total++; if (if_id_pc !== 16'h0006 || if_id_valid !== 1'b1) begin bad++; $display("FAIL wait_last: got pc=%h v=%b want 0006/1", if_id_pc, if_id_valid); end
            end else begin
                total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL wait_bubble%0d: got %b want 0", k, if_id_valid); end
            end
            $display("wait %0d: addr=%h valid=%b", k, imem_addr, if_id_valid);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL wait_bubble3: got %b want 0", if_id_valid); end
        total++; if (next_address !== 16'h000A) begin bad++; $display("FAIL wait_resume: got %h want 000A", next_address); end
        $display("wait resume: addr=%h next=%h", imem_addr, next_address);
    endtask

    task automatic test_stall_skid();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        total++; if (if_id_pc !== 16'h0008 || if_id_instr !== 16'hA5AD || if_id_valid !== 1'b1) begin bad++; $display("FAIL stall_pre: got pc=%h i=%h v=%b want 0008/A5AD/1", if_id_pc, if_id_instr, if_id_valid); end
        total++; if (next_address !== 16'h000C) begin bad++; $display("FAIL stall_next: got %h want 000C", next_address); end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL hold_req: got %b want 0", imem_req); end
        total++; if (next_address !== 16'h000C) begin bad++; $display("FAIL hold_next: got %h want 000C", next_address); end
        total++; if (if_id_pc !== 16'h0008 || if_id_valid !== 1'b1) begin bad++; $display("FAIL hold_ifid: got pc=%h v=%b want 0008/1", if_id_pc, if_id_valid); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL release_req: got %b want 0", imem_req); end
        total++; if (if_id_pc !== 16'h0008) begin bad++; $display("FAIL release_pc: got %h want 0008", if_id_pc); end
        $display("stall: req=%b pc=%h", imem_req, if_id_pc);
    endtask

    task automatic test_flush();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0123);
        total++; if (if_id_pc !== 16'h000A || if_id_instr !== 16'hA5AF || if_id_pc_plus2 !== 16'h000C || if_id_valid !== 1'b1) begin bad++; $display("FAIL skid_out: got pc=%h i=%h p2=%h v=%b want 000A/A5AF/000C/1", if_id_pc, if_id_instr, if_id_pc_plus2, if_id_valid); end
        total++; if (imem_addr !== 16'h000C || imem_req !== 1'b1) begin bad++; $display("FAIL skid_fetch: got %h/%b want 000C/1", imem_addr, imem_req); end
        total++; if (next_address !== 16'h0122) begin bad++; $display("FAIL flush_next: got %h want 0122", next_address); end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        total++; if (if_id_valid !== 1'b0 || if_id_instr !== 16'h0000) begin bad++; $display("FAIL flush_clear: got v=%b i=%h want 0/0000", if_id_valid, if_id_instr); end
        total++; if (imem_addr !== 16'h0122) begin bad++; $display("FAIL flush_addr: got %h want 0122", imem_addr); end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFD);
        total++; if (if_id_pc !== 16'h0122 || if_id_instr !== 16'hA487 || if_id_valid !== 1'b1) begin bad++; $display("FAIL flush_fetch: got pc=%h i=%h v=%b want 0122/A487/1", if_id_pc, if_id_instr, if_id_valid); end
        total++; if (next_address !== 16'hFFFC) begin bad++; $display("FAIL align_next: got %h want FFFC", next_address); end
        $display("flush: pc=%h next=%h", if_id_pc, next_address);
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
`ifdef FETCH_PERF_EN
        snap_fetched = perf_fetched;
        snap_bubbles = perf_bubbles;
`endif
        total++; if (imem_addr !== 16'hFFFC || next_address !== 16'hFFFE) begin bad++; $display("FAIL wrap_a: got %h/%h want FFFC/FFFE", imem_addr, next_address); end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        total++; if (next_address !== 16'h0000) begin bad++; $display("FAIL wrap_next: got %h want 0000", next_address); end
        total++; if (if_id_pc !== 16'hFFFC || if_id_pc_plus2 !== 16'hFFFE || if_id_instr !== 16'h5A59) begin bad++; $display("FAIL wrap_b: got %h/%h/%h want FFFC/FFFE/5A59", if_id_pc, if_id_pc_plus2, if_id_instr); end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        total++; if (if_id_pc !== 16'hFFFE || if_id_pc_plus2 !== 16'h0000 || if_id_instr !== 16'h5A5B) begin bad++; $display("FAIL wrap_c: got %h/%h/%h want FFFE/0000/5A5B", if_id_pc, if_id_pc_plus2, if_id_instr); end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        total++; if (if_id_pc !== 16'h0000 || if_id_pc_plus2 !== 16'h0002 || if_id_valid !== 1'b1) begin bad++; $display("FAIL wrap_d: got %h/%h/%b want 0000/0002/1", if_id_pc, if_id_pc_plus2, if_id_valid); end
`ifdef FETCH_PERF_EN
        total++; if (16'(perf_fetched - snap_fetched) !== 16'd3) begin bad++; $display("FAIL perf_fetched: got %0d want 3", 16'(perf_fetched - snap_fetched)); end
        total++; if (16'(perf_bubbles - snap_bubbles) !== 16'd0) begin bad++; $display("FAIL perf_bubbles: got %0d want 0", 16'(perf_bubbles - snap_bubbles)); end
`endif
        $display("wrap: pc=%h pc2=%h", if_id_pc, if_id_pc_plus2);
    endtask

    task automatic test_reset_mid_fetch();
        total++; if (next_address !== 16'h0000 || imem_req !== 1'b0) begin bad++; $display("FAIL rst_mid_comb: got %h/%b want 0000/0", next_address, imem_req); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        total++; if (if_id_valid !== 1'b0 || if_id_instr !== 16'h0000 || if_id_pc !== 16'h0000 || if_id_pc_plus2 !== 16'h0000) begin bad++; $display("FAIL rst_mid_ifid: got %b/%h/%h/%h want 0/0000/0000/0000", if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus2); end
        total++; if (imem_addr !== 16'h0000 || imem_req !== 1'b1) begin bad++; $display("FAIL rst_mid_fetch: got %h/%b want 0000/1", imem_addr, imem_req); end
`ifdef FETCH_PERF_EN
        total++; if (perf_fetched !== 16'd0 || perf_bubbles !== 16'd0) begin bad++; $display("FAIL rst_mid_perf: got %0d/%0d want 0/0", perf_fetched, perf_bubbles); end
`endif
        $display("reset mid-fetch: valid=%b addr=%h", if_id_valid, imem_addr);
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_wait_states();
        test_stall_skid();
        test_flush();
        test_wrap();
        test_reset_mid_fetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
